// File: rtl/lh_msg_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lh_msg_scheduler
// Purpose  : Multi-requester front end for the light-hash core. Arbitrates
//            round-robin between N_REQ byte-stream requesters. Frames the
//            granted message as HEAD_BYTE, payload, TAIL_BYTE and streams it
//            to the core one byte per cycle. Returns the core digest, tagged
//            with the requester id. Illegal bytes, oversize messages and a
//            core that never answers are all reported via rsp_err.
//
// Ports    : clk, rst_n          clock / synchronous active-low reset
//            req_valid/byte/last  per-requester byte streams (8 bits each)
//            req_ready            one-hot accept for the granted requester
//            rsp_valid/ready      response handshake
//            rsp_id/digest/err    response payload (digest is 0 on error)
//            core_byte/valid      byte stream into the hash core
//            core_digest(_ready)  digest result pulse from the hash core
//            busy                 high whenever a transaction is in progress
//
// Revision : 1.0  initial release
// ============================================================================
module lh_msg_scheduler #(
  parameter int         N_REQ     = 2,
  parameter int         MAX_LEN   = 32,
  parameter logic [7:0] HEAD_BYTE = 8'hFF,
  parameter logic [7:0] TAIL_BYTE = 8'h00,
  parameter int         TIMEOUT   = 64,
  localparam int        c_ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_byte,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [c_ID_W-1:0]    rsp_id,
  output logic [63:0]          rsp_digest,
  output logic                 rsp_err,
  output logic [7:0]           core_byte,
  output logic                 core_valid,
  input  logic [63:0]          core_digest,
  input  logic                 core_digest_ready,
  output logic                 busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_LEN_W = $clog2(MAX_LEN + 1);
  localparam int c_TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_LEN_W-1:0] c_LEN_MAX  = c_LEN_W'(MAX_LEN);
  localparam logic [c_TMR_W-1:0] c_TMO_LAST = c_TMR_W'(TIMEOUT - 1);
  localparam logic [c_ID_W-1:0]  c_ID_LAST  = c_ID_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAD = 3'd1,
    S_DATA = 3'd2,
    S_TAIL = 3'd3,
    S_WAIT = 3'd4,
    S_RESP = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [c_ID_W-1:0]    r_gnt;
  logic [c_ID_W-1:0]    r_rr_ptr;
  logic [c_LEN_W-1:0]   r_len;
  logic                 r_err;
  logic [c_TMR_W-1:0]   r_timer;

  logic [N_REQ-1:0]     r_req_ready;
  logic                 r_rsp_valid;
  logic [c_ID_W-1:0]    r_rsp_id;
  logic [63:0]          r_rsp_digest;
  logic                 r_rsp_err;
  logic [7:0]           r_core_byte;
  logic                 r_core_valid;
  logic                 r_busy;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [7:0]           w_byte_arr [N_REQ];
  logic [N_REQ-1:0]     w_gnt_oh;
  logic [7:0]           w_gnt_byte;
  logic                 w_gnt_last;
  logic                 w_hs;
  logic                 w_bad;
  logic                 w_gnt_found;
  logic [c_ID_W-1:0]    w_gnt_idx;
  logic [c_ID_W-1:0]    w_cand;
  logic [c_ID_W-1:0]    w_rr_next;

  // Split the flat byte bus into per-requester lanes and build the one-hot
  // accept mask for the currently granted requester.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign w_byte_arr[gi] = req_byte[8*gi +: 8];
    assign w_gnt_oh[gi]   = (r_gnt == c_ID_W'(gi));
  end

  assign w_gnt_byte = w_byte_arr[r_gnt];
  assign w_gnt_last = req_last[r_gnt];
  assign w_hs       = (r_state == S_DATA) && req_valid[r_gnt] && r_req_ready[r_gnt];

  // Markers inside the payload would corrupt the core framing, and bytes past
  // MAX_LEN would overflow the message; both are swallowed and flagged.
  assign w_bad = (w_gnt_byte == HEAD_BYTE) || (w_gnt_byte == TAIL_BYTE) ||
                 (r_len == c_LEN_MAX);

  assign w_rr_next = (r_gnt == c_ID_LAST) ? '0 : r_gnt + 1'b1;

  // Round-robin search starting at r_rr_ptr. The loop runs from the farthest
  // candidate down to the nearest so the nearest valid requester wins.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = c_ID_W'((int'(r_rr_ptr) + k) % N_REQ);
      if (req_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Main FSM. Every output is a register; each state sets up the values the
  // outside world sees in the following cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_rr_ptr     <= '0;
      r_len        <= '0;
      r_err        <= 1'b0;
      r_timer      <= '0;
      r_req_ready  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_digest <= '0;
      r_rsp_err    <= 1'b0;
      r_core_byte  <= HEAD_BYTE;
      r_core_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Idle core lane always carries HEAD_BYTE so the core stays in its
      // digest-init condition between frames.
      r_core_valid <= 1'b0;
      r_core_byte  <= HEAD_BYTE;

      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            r_gnt        <= w_gnt_idx;
            r_len        <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b1;
            r_core_valid <= 1'b1;          // head marker shown during HEAD
            r_core_byte  <= HEAD_BYTE;
            r_state      <= S_HEAD;
          end
        end

        S_HEAD: begin
          r_req_ready <= w_gnt_oh;
          r_state     <= S_DATA;
        end

        S_DATA: begin
          if (w_hs) begin
            if (r_len != c_LEN_MAX) begin
              r_len <= r_len + 1'b1;
            end
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_core_valid <= 1'b1;
              r_core_byte  <= w_gnt_byte;
            end
            // Oversize messages keep being accepted until req_last so the
            // requester is always drained.
            if (w_gnt_last) begin
              r_req_ready <= '0;
              r_state     <= S_TAIL;
            end
          end
        end

        // The last payload byte is on the core lane during this state; the
        // tail marker is registered here and appears as WAIT starts, closing
        // the frame even for errored messages.
        S_TAIL: begin
          r_core_valid <= 1'b1;
          r_core_byte  <= TAIL_BYTE;
          r_timer      <= '0;
          r_state      <= S_WAIT;
        end

        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          // A digest arriving on the final timeout cycle is still taken.
          if (core_digest_ready) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_gnt;
            r_rsp_err    <= r_err;
            r_rsp_digest <= r_err ? '0 : core_digest;
            r_state      <= S_RESP;
          end else if (r_timer == c_TMO_LAST) begin
            r_err        <= 1'b1;
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_gnt;
            r_rsp_err    <= 1'b1;
            r_rsp_digest <= '0;
            r_state      <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= w_rr_next;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_digest = r_rsp_digest;
  assign rsp_err    = r_rsp_err;
  assign core_byte  = r_core_byte;
  assign core_valid = r_core_valid;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_lh_msg_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lh_msg_scheduler
// Purpose  : Directed self-checking bench for lh_msg_scheduler (N_REQ=2,
//            MAX_LEN=32, TIMEOUT=64). Requesters are byte queues, the hash
//            core is a fixed-latency digest responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_lh_msg_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_byte;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [63:0] rsp_digest;
  logic        rsp_err;
  logic [7:0]  core_byte;
  logic        core_valid;
  logic [63:0] core_digest;
  logic        core_digest_ready;
  logic        busy;

  lh_msg_scheduler #(
    .N_REQ(2), .MAX_LEN(32), .HEAD_BYTE(8'hFF), .TAIL_BYTE(8'h00), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_byte(req_byte), .req_last(req_last), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_digest(rsp_digest), .rsp_err(rsp_err),
    .core_byte(core_byte), .core_valid(core_valid),
    .core_digest(core_digest), .core_digest_ready(core_digest_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] DIG_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DIG_B = 64'hFEDC_BA98_7654_3210;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs0, hs1, tail_cyc, rise_cyc, core_cnt, core_lat, t_start;
  bit core_en;
  logic rsp_prev;

  logic [7:0]  q0b[$], q1b[$], core_log[$], exp_log[$];
  logic        q0l[$], q1l[$];
  logic [0:0]  rq_id[$];
  logic        rq_err[$];
  logic [63:0] rq_dig[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [7:0] b, input logic l);
    q0b.push_back(b); q0l.push_back(l);
  endtask

  task automatic push1(input logic [7:0] b, input logic l);
    q1b.push_back(b); q1l.push_back(l);
  endtask

  task automatic ex(input logic [7:0] b);
    exp_log.push_back(b);
  endtask

  task automatic drive_reqs();
    req_valid = 2'b00; req_byte = 16'h0000; req_last = 2'b00;
    if (q0b.size() > 0) begin req_valid[0] = 1'b1; req_byte[7:0]  = q0b[0]; req_last[0] = q0l[0]; end
    if (q1b.size() > 0) begin req_valid[1] = 1'b1; req_byte[15:8] = q1b[0]; req_last[1] = q1l[0]; end
  endtask

  task automatic clr();
    core_log.delete(); exp_log.delete();
    rq_id.delete(); rq_err.delete(); rq_dig.delete();
    hs0 = 0; hs1 = 0;
  endtask

  // One clock: observe at the falling edge, update stimulus 1ns after rising.
  task automatic tick();
    logic [1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    if (rst_n) chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
    if (core_valid) core_log.push_back(core_byte);
    if (core_valid && core_byte == 8'h00) begin
      tail_cyc = cyc;
      if (core_en) core_cnt = core_lat;
    end
    if (rsp_valid && !rsp_prev) rise_cyc = cyc;
    rsp_prev = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      rq_id.push_back(rsp_id); rq_err.push_back(rsp_err); rq_dig.push_back(rsp_digest);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hs[0]) begin void'(q0b.pop_front()); void'(q0l.pop_front()); hs0++; end
    if (hs[1]) begin void'(q1b.pop_front()); void'(q1l.pop_front()); hs1++; end
    drive_reqs();
    core_digest_ready = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) core_digest_ready = 1'b1;
    end
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k;
    k = 0;
    while (rq_id.size() < n && k < budget) begin tick(); k++; end
    chk("rsp_count", 64'(rq_id.size()), 64'(n));
  endtask

  task automatic chk_log(input string tag);
    logic [7:0] got;
    chk({tag, "_n"}, 64'(core_log.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      got = (i < core_log.size()) ? core_log[i] : 8'hxx;
      chk($sformatf("%s_%0d", tag, i), {56'd0, got}, {56'd0, exp_log[i]});
    end
  endtask

  task automatic chk_rsp(input string tag, input int i, input logic [0:0] id,
                         input logic err, input logic [63:0] dig);
    if (i < rq_id.size()) begin
      chk({tag, "_id"},  64'(rq_id[i]),  64'(id));
      chk({tag, "_err"}, 64'(rq_err[i]), 64'(err));
      chk({tag, "_dig"}, rq_dig[i], dig);
    end else begin
      chk({tag, "_present"}, 64'(rq_id.size()), 64'(i + 1));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(req_ready),  64'd0);
    chk({tag, "_rsp_valid"},  64'(rsp_valid),  64'd0);
    chk({tag, "_rsp_id"},     64'(rsp_id),     64'd0);
    chk({tag, "_rsp_digest"}, rsp_digest,      64'd0);
    chk({tag, "_rsp_err"},    64'(rsp_err),    64'd0);
    chk({tag, "_core_byte"},  64'(core_byte),  64'hFF);
    chk({tag, "_core_valid"}, 64'(core_valid), 64'd0);
    chk({tag, "_busy"},       64'(busy),       64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; req_valid = '0; req_byte = '0; req_last = '0; rsp_ready = 1'b1;
    core_digest = DIG_A; core_digest_ready = 1'b0;
    core_en = 1'b1; core_lat = 1; core_cnt = 0; rsp_prev = 1'b0;
    tail_cyc = 0; rise_cyc = 0; t_start = 0;
    clr();

    // ---- Reset state ----
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // ---- Single message "abc" from req0, D=1 ----
    clr();
    push0(8'h61, 1'b0); push0(8'h62, 1'b0); push0(8'h63, 1'b1);
    drive_reqs(); t_start = cyc;
    wait_rsp(1, 100);
    ex(8'hFF); ex(8'h61); ex(8'h62); ex(8'h63); ex(8'h00);
    chk_log("abc_core");
    chk_rsp("abc", 0, 1'b0, 1'b0, DIG_A);
    chk("abc_latency", 64'(rise_cyc - t_start), 64'd8);   // L+4+D, L=3 D=1
    chk("abc_idle_busy", 64'(busy), 64'd0);

    // ---- Illegal byte from req1 (rr_ptr now 1) ----
    clr();
    push1(8'h41, 1'b0); push1(8'hFF, 1'b0); push1(8'h42, 1'b1);
    drive_reqs();
    wait_rsp(1, 100);
    ex(8'hFF); ex(8'h41); ex(8'h42); ex(8'h00);
    chk_log("ill_core");
    chk_rsp("ill", 0, 1'b1, 1'b1, 64'd0);

    // ---- Fairness: both requesters continuously valid (rr_ptr now 0) ----
    clr();
    push0(8'h01, 1'b0); push0(8'h02, 1'b1); push0(8'h03, 1'b0); push0(8'h04, 1'b1);
    push1(8'h11, 1'b0); push1(8'h12, 1'b1); push1(8'h13, 1'b0); push1(8'h14, 1'b1);
    drive_reqs();
    wait_rsp(4, 200);
    chk_rsp("rr0", 0, 1'b0, 1'b0, DIG_A);
    chk_rsp("rr1", 1, 1'b1, 1'b0, DIG_A);
    chk_rsp("rr2", 2, 1'b0, 1'b0, DIG_A);
    chk_rsp("rr3", 3, 1'b1, 1'b0, DIG_A);
    ex(8'hFF); ex(8'h01); ex(8'h02); ex(8'h00);
    ex(8'hFF); ex(8'h11); ex(8'h12); ex(8'h00);
    ex(8'hFF); ex(8'h03); ex(8'h04); ex(8'h00);
    ex(8'hFF); ex(8'h13); ex(8'h14); ex(8'h00);
    chk_log("rr_core");

    // ---- Oversize: 33 bytes of 0x55 from req0 ----
    clr();
    for (int i = 0; i < 33; i++) push0(8'h55, (i == 32));
    drive_reqs();
    wait_rsp(1, 200);
    ex(8'hFF);
    for (int i = 0; i < 32; i++) ex(8'h55);
    ex(8'h00);
    chk_log("ovr_core");
    chk("ovr_accepted", 64'(hs0), 64'd33);
    chk_rsp("ovr", 0, 1'b0, 1'b1, 64'd0);

    // ---- Timeout with response backpressure (rr_ptr now 1, req0 only) ----
    clr();
    core_en = 1'b0; rsp_ready = 1'b0;
    push0(8'h10, 1'b0); push0(8'h20, 1'b1);
    drive_reqs();
    k = 0;
    while (!rsp_valid && k < 150) begin tick(); k++; end
    chk("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("tmo_after_tail", 64'(cyc - tail_cyc), 64'd64);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) begin core_digest = DIG_B; core_digest_ready = 1'b1; end
      chk($sformatf("tmo_hold_%0d", i), 64'({rsp_valid, rsp_err, rsp_id, busy}), 64'b1101);
      chk($sformatf("tmo_hold_dig_%0d", i), rsp_digest, 64'd0);
    end
    core_digest = DIG_A; core_en = 1'b1; rsp_ready = 1'b1;
    wait_rsp(1, 10);
    chk_rsp("tmo", 0, 1'b0, 1'b1, 64'd0);

    // ---- Digest on the final timeout cycle wins ----
    clr();
    core_lat = 63; core_digest = DIG_B;
    push0(8'h5A, 1'b1);
    drive_reqs();
    wait_rsp(1, 150);
    chk_rsp("edge", 0, 1'b0, 1'b0, DIG_B);
    chk("edge_after_tail", 64'(rise_cyc - tail_cyc), 64'd64);
    core_lat = 1; core_digest = DIG_A;

    // ---- Reset in the middle of a req1 message (rr_ptr now 1) ----
    clr();
    push1(8'h21, 1'b0); push1(8'h22, 1'b0); push1(8'h23, 1'b1);
    drive_reqs();
    k = 0;
    while (hs1 < 2 && k < 20) begin tick(); k++; end
    chk("abort_bytes", 64'(hs1), 64'd2);
    rst_n = 1'b0;
    q1b.delete(); q1l.delete();
    drive_reqs();
    tick();
    chk_reset_outputs("mid");
    rst_n = 1'b1;
    clr(); core_cnt = 0;
    push0(8'h31, 1'b1);
    push1(8'h24, 1'b0); push1(8'h25, 1'b1);
    drive_reqs();
    wait_rsp(2, 100);
    chk_rsp("post0", 0, 1'b0, 1'b0, DIG_A);   // rr_ptr back at 0: req0 first
    chk_rsp("post1", 1, 1'b1, 1'b0, DIG_A);
    ex(8'hFF); ex(8'h31); ex(8'h00);
    ex(8'hFF); ex(8'h24); ex(8'h25); ex(8'h00);
    chk_log("post_core");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
